writeback_port_scheduler: RTL and testbench
===========================================

Name: writeback_port_scheduler

Overview:
Shares the single register-file write port between two result producers. The ALU path supplies rt/rd fields plus a RegDst code. The multi-cycle multiply/divide/load path (MDU) supplies a resolved destination. The block resolves the ALU destination (rt, rd or link register), arbitrates with ALU priority plus MDU starvation protection, suppresses writes to $zero, and drives a registered write port into the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width
LINK_REG, 31, destination used for RegDst=link (jal)
STARVE_LIMIT, 3, consecutive MDU wait cycles before MDU is forced a grant (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
alu_reg_dst  in  2  00=rt, 01=rd, 10=LINK_REG, 11=illegal
alu_rt  in  ADDR_W  instruction rt field
alu_rd  in  ADDR_W  instruction rd field
alu_data  in  DATA_W  ALU result
mdu_valid  in  1  MDU result available
mdu_ready  out  1  MDU result accepted this cycle when mdu_valid=1
mdu_dest  in  ADDR_W  MDU destination register
mdu_data  in  DATA_W  MDU result
rf_we  out  1  register-file write enable, registered
rf_waddr  out  ADDR_W  write address, registered
rf_wdata  out  DATA_W  write data, registered
starve_active  out  1  high while state=FORCE_MDU
dst_err  out  1  one-cycle pulse, registered: ALU accepted with reg_dst=11

Behaviour:
- Handshake: a transfer occurs when valid && ready in cycle N. The write appears on rf_we/rf_waddr/rf_wdata in cycle N+1 for exactly one cycle. Latency is 1. Throughput is one write per cycle.
- Requesters hold valid, data and dest stable until ready. The block does not buffer un-accepted requests.
- ready outputs are combinational from state and valids, with no dependency on rf_* outputs.
- Destination resolution (ALU): 00 selects alu_rt, 01 selects alu_rd, 10 selects LINK_REG. 11 is accepted with no write (rf_we=0) and dst_err pulses in N+1.
- $zero: any accepted transfer resolving to address 0 is consumed, and rf_we stays 0 in N+1.
- FSM states:
  - PRIO_ALU: alu_ready=1; mdu_ready=!alu_valid.
  - FORCE_MDU: mdu_ready=1; alu_ready=!mdu_valid.
- Starve counter (4-bit, saturating):
  - +1 at each edge where mdu_valid && !mdu_ready.
  - Cleared at each edge where the MDU transfer occurs.
  - PRIO_ALU->FORCE_MDU at the edge where the counter reaches STARVE_LIMIT.
  - FORCE_MDU->PRIO_ALU at the edge following an MDU transfer, or when mdu_valid=0; the counter is cleared in both cases.
- Simultaneous valids: exactly one is granted per cycle, never both.
- When no transfer occurs, rf_we=0 next cycle. rf_waddr and rf_wdata hold their last values.
- Reset, with all effects at the next edge:
  - State=PRIO_ALU, counter=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, dst_err=0, starve_active=0.
  - A transfer accepted in the same cycle reset is high is discarded.
  - While reset=1, alu_ready=mdu_ready=0.
- STARVE_LIMIT=1: MDU is forced after a single lost cycle.

Decomposition:
- Shared package wb_pkg holds:
  - RegDst codes REGDST_RT/RD/LINK/ILL.
  - State enum {PRIO_ALU, FORCE_MDU}.
  - Width constants DATA_W/ADDR_W.
  The same RegDst codes are used by the control unit.
- One sub-module, dest_resolve: combinational rt/rd/link selector with an illegal flag.
- Arbiter FSM, counter and output register stay in the top module.

Test Plan:
1. ALU only, reg_dst=01, rt=5'b01010, rd=5'b11111, data=0xDEADBEEF, one cycle -> next cycle rf_we=1, rf_waddr=31, rf_wdata=0xDEADBEEF; then rf_we=0.
2. ALU reg_dst=00, rt=10 -> rf_waddr=10. reg_dst=10 -> rf_waddr=31. reg_dst=11 -> rf_we=0, dst_err=1 for one cycle.
3. Starvation:
   - Stimulus: STARVE_LIMIT=3; alu_valid held high cycles 0-6; mdu_valid held high from cycle 0 with dest=8, data=0x1234.
   - Cycles 0-2: ALU granted.
   - Cycle 3: starve_active=1, mdu_ready=1, alu_ready=0.
   - Cycle 4: rf_waddr=8, rf_wdata=0x1234; state back to PRIO_ALU, ALU granted again.
4. MDU only, dest=0, data=0xFFFFFFFF -> mdu_ready=1 same cycle; rf_we stays 0.
5. Reset mid-operation: ALU transfer accepted in the cycle reset=1 -> rf_we=0 next cycle; all outputs zero; counter=0 verified by starvation recurring exactly 3 cycles after reset release.
6. Both idle 10 cycles after traffic -> rf_we=0 throughout, ready outputs track the FSM rules, starve_active=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: RegDst encodings
// (also decoded by the control unit), arbiter states and default widths.
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;
    localparam logic [1:0] REGDST_ILL  = 2'b11;

    typedef enum logic {
        PRIO_ALU  = 1'b0,
        FORCE_MDU = 1'b1
    } wb_state_e;
endpackage

// File: rtl/dest_resolve.sv
// Combinational ALU destination selector: rt, rd or the link register.
// The reserved RegDst code yields address 0 and raises illegal.
module dest_resolve
    import wb_pkg::*;
#(
    parameter int ADDR_W   = wb_pkg::ADDR_W,
    parameter int LINK_REG = 31
) (
    input  logic [1:0]        reg_dst,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] dest,
    output logic              illegal
);
    always_comb begin
        dest    = '0;
        illegal = 1'b0;
        case (reg_dst)
            REGDST_RT:   dest = rt;
            REGDST_RD:   dest = rd;
            REGDST_LINK: dest = ADDR_W'(LINK_REG);
            default:     illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/writeback_port_scheduler.sv
// Arbitrates the single register-file write port between the ALU and the MDU:
// ALU priority with a starvation counter that forces one MDU grant.
module writeback_port_scheduler
    import wb_pkg::*;
#(
    parameter int DATA_W       = wb_pkg::DATA_W,
    parameter int ADDR_W       = wb_pkg::ADDR_W,
    parameter int LINK_REG     = 31,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [1:0]        alu_reg_dst,
    input  logic [ADDR_W-1:0] alu_rt,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              starve_active,
    output logic              dst_err
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_state_e         state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              dst_err_q, dst_err_d;
    logic [ADDR_W-1:0] alu_dest;
    logic              alu_ill;
    logic              alu_xfer, mdu_xfer;

    dest_resolve #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_dest_resolve (
        .reg_dst (alu_reg_dst),
        .rt      (alu_rt),
        .rd      (alu_rd),
        .dest    (alu_dest),
        .illegal (alu_ill)
    );

    // Readies depend only on state and the valids, so at most one side is granted.
    always_comb begin
        alu_ready = 1'b0;
        mdu_ready = 1'b0;
        if (!reset) begin
            if (state_q == PRIO_ALU) begin
                alu_ready = 1'b1;
                mdu_ready = !alu_valid;
            end else begin
                mdu_ready = 1'b1;
                alu_ready = !mdu_valid;
            end
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign mdu_xfer = mdu_valid && mdu_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = state_q;
        if (mdu_xfer)
            starve_cnt_d = '0;
        else if (mdu_valid && !mdu_ready && starve_cnt_q != 4'hF)
            starve_cnt_d = starve_cnt_q + 4'd1;

        case (state_q)
            PRIO_ALU: if (starve_cnt_d == LIMIT) state_d = FORCE_MDU;
            default: begin
                state_d      = PRIO_ALU;
                starve_cnt_d = '0;
            end
        endcase

        // Writes to $zero and illegal RegDst are consumed without touching the port.
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        dst_err_d  = alu_xfer && alu_ill;
        if (alu_xfer && !alu_ill && alu_dest != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_dest;
            rf_wdata_d = alu_data;
        end else if (mdu_xfer && mdu_dest != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mdu_dest;
            rf_wdata_d = mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIO_ALU;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            dst_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            dst_err_q    <= dst_err_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign dst_err       = dst_err_q;
    assign starve_active = (state_q == FORCE_MDU);
endmodule

// File: tb/tb_writeback_port_scheduler.sv
// Directed table-driven bench for writeback_port_scheduler plus hand-written
// reset, idle and STARVE_LIMIT=1 sequences.
module tb_writeback_port_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mdu_valid;
    logic [1:0]  alu_reg_dst;
    logic [4:0]  alu_rt, alu_rd, mdu_dest;
    logic [31:0] alu_data, mdu_data;

    logic        alu_ready, mdu_ready, rf_we, starve_active, dst_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        l1_alu_ready, l1_mdu_ready, l1_rf_we, l1_starve, l1_dst_err;
    logic [4:0]  l1_rf_waddr;
    logic [31:0] l1_rf_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_port_scheduler #(.STARVE_LIMIT(3)) u_dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg_dst(alu_reg_dst),
        .alu_rt(alu_rt), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .starve_active(starve_active), .dst_err(dst_err)
    );

    writeback_port_scheduler #(.STARVE_LIMIT(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(l1_alu_ready), .alu_reg_dst(alu_reg_dst),
        .alu_rt(alu_rt), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(l1_mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
        .rf_we(l1_rf_we), .rf_waddr(l1_rf_waddr), .rf_wdata(l1_rf_wdata),
        .starve_active(l1_starve), .dst_err(l1_dst_err)
    );

    typedef struct {
        logic        av;
        logic [1:0]  rdst;
        logic [4:0]  rt, rd;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        e_ar, e_mr, e_st, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_err, chk_ad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic av, input logic [1:0] rdst, input logic [4:0] rt, input logic [4:0] rd,
        input logic [31:0] ad, input logic mv, input logic [4:0] md, input logic [31:0] mdat,
        input logic ar, input logic mr, input logic st, input logic we,
        input logic [4:0] wa, input logic [31:0] wd, input logic err, input logic ck);
        vec_t v;
        v.av = av; v.rdst = rdst; v.rt = rt; v.rd = rd; v.ad = ad;
        v.mv = mv; v.md = md; v.mdat = mdat;
        v.e_ar = ar; v.e_mr = mr; v.e_st = st; v.e_we = we;
        v.e_wa = wa; v.e_wd = wd; v.e_err = err; v.chk_ad = ck;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] rdst, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] ad,
                         input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        alu_valid = av; alu_reg_dst = rdst; alu_rt = rt; alu_rd = rd; alu_data = ad;
        mdu_valid = mv; mdu_dest = md; mdu_data = mdat;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Vectors: readies/starve_active are checked in the applying cycle,
        // rf_* and dst_err just after the following edge.
        vecs.push_back(mk(1, 2'b01, 5'd10, 5'd31, 32'hDEADBEEF, 0, 0, 0,     1, 0, 0, 1, 5'd31, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 5'd31, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(1, 2'b00, 5'd10, 5'd31, 32'h11111111, 0, 0, 0,     1, 0, 0, 1, 5'd10, 32'h11111111, 0, 1));
        vecs.push_back(mk(1, 2'b10, 5'd10, 5'd3, 32'h22222222, 0, 0, 0,      1, 0, 0, 1, 5'd31, 32'h22222222, 0, 1));
        vecs.push_back(mk(1, 2'b11, 5'd10, 5'd3, 32'h33333333, 0, 0, 0,      1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b00, 5'd0, 5'd5, 32'h00000044, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF,              1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5'd7, 32'h00000055,              1, 1, 0, 1, 5'd7, 32'h00000055, 0, 1));
        for (int k = 0; k < 7; k++) begin
            if (k == 3)
                vecs.push_back(mk(1, 2'b01, 0, 5'(k + 1), 32'hA0 + k, 1, 5'd8, 32'h1234,
                                  0, 1, 1, 1, 5'd8, 32'h1234, 0, 1));
            else
                vecs.push_back(mk(1, 2'b01, 0, 5'(k + 1), 32'hA0 + k, 1, 5'd8, 32'h1234,
                                  1, 0, 0, 1, 5'(k + 1), 32'hA0 + k, 0, 1));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5'd8, 32'h1234,                  0, 1, 1, 1, 5'd8, 32'h1234, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 1, 0, 0, 5'd8, 32'h1234, 0, 1));

        // Power-on reset: readies low, outputs cleared.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("rst alu_ready", alu_ready, 0);
            chk("rst mdu_ready", mdu_ready, 0);
            @(posedge clk); #1;
        end
        chk("rst rf_we", rf_we, 0);
        chk("rst rf_waddr", rf_waddr, 0);
        chk("rst rf_wdata", rf_wdata, 0);
        chk("rst dst_err", dst_err, 0);
        chk("rst starve", starve_active, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].rdst, vecs[i].rt, vecs[i].rd, vecs[i].ad,
                  vecs[i].mv, vecs[i].md, vecs[i].mdat);
            #1;
            chk($sformatf("v%0d alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("v%0d mdu_ready", i), mdu_ready, vecs[i].e_mr);
            chk($sformatf("v%0d starve", i), starve_active, vecs[i].e_st);
            @(posedge clk); #1;
            chk($sformatf("v%0d rf_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("v%0d dst_err", i), dst_err, vecs[i].e_err);
            if (vecs[i].chk_ad) begin
                chk($sformatf("v%0d rf_waddr", i), rf_waddr, vecs[i].e_wa);
                chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_wd);
            end
        end

        // Build up two lost MDU cycles, then reset with an ALU transfer pending.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1, 2'b01, 0, 5'd9, 32'h99, 1, 5'd8, 32'h1234);
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst alu_ready", alu_ready, 0);
        chk("midrst mdu_ready", mdu_ready, 0);
        @(posedge clk); #1;
        chk("midrst rf_we", rf_we, 0);
        chk("midrst rf_waddr", rf_waddr, 0);
        chk("midrst rf_wdata", rf_wdata, 0);
        chk("midrst dst_err", dst_err, 0);
        chk("midrst starve", starve_active, 0);
        chk("midrst l1 starve", l1_starve, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("post%0d starve", c), starve_active, (c == 3) ? 1 : 0);
            chk($sformatf("post%0d alu_ready", c), alu_ready, (c == 3) ? 0 : 1);
            chk($sformatf("post%0d mdu_ready", c), mdu_ready, (c == 3) ? 1 : 0);
            if (c < 2) chk($sformatf("post%0d l1 starve", c), l1_starve, (c == 1) ? 1 : 0);
            @(posedge clk); #1;
            chk($sformatf("post%0d rf_we", c), rf_we, 1);
            chk($sformatf("post%0d rf_waddr", c), rf_waddr, (c == 3) ? 5'd8 : 5'd9);
            @(negedge clk);
        end

        // Idle after traffic.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("idle%0d alu_ready", c), alu_ready, 1);
            chk($sformatf("idle%0d mdu_ready", c), mdu_ready, 1);
            chk($sformatf("idle%0d starve", c), starve_active, 0);
            @(posedge clk); #1;
            chk($sformatf("idle%0d rf_we", c), rf_we, 0);
            @(negedge clk);
        end
        chk("idle hold rf_waddr", rf_waddr, 5'd8);
        chk("idle hold rf_wdata", rf_wdata, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
